sn_dispatch_arbiter: RTL

SN_DISPATCH_ARBITER -- requirements
Module: sn_dispatch_arbiter

---
 rtl/sn_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 29 ++
 rtl/sn_dispatch_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/sn_arb_pkg.sv
// Shared definitions for the snooper dispatch arbiter.
// FSM encoding and the select-width helper macro.
`ifndef SN_ARB_PKG_SV
`define SN_ARB_PKG_SV

// Index width for n cores; never narrower than one bit.
`define SN_CLOG2(n) (((n) <= 2) ? 1 : $clog2(n))

package sn_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_t;

endpackage

`endif

// File: rtl/rr_pick.sv
// Round-robin picker: first set mask bit at or after ptr.
// Purely combinational, wraps past the top core.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  int j;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (mask[j]) begin
        idx   = W'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sn_dispatch_arbiter.sv
// Dispatches snooper packets to ready cores, round-robin.
// Offers one core, forwards its strobes until end-of-packet.
import sn_arb_pkg::*;

module sn_dispatch_arbiter #(
  parameter int N_CORES           = 4,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int INC_WIDTH         = 4,
  localparam int SEL_W = `SN_CLOG2(N_CORES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
  input  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
  input  logic [INC_WIDTH-1:0]         sn_byte_inc,
  input  logic                         sn_wr_en,
  input  logic                         sn_done,
  output logic                         rdy_for_sn,
  input  logic                         rdy_for_sn_ack,
  output logic [SN_FWD_ADDR_WIDTH-1:0] core_sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0] core_sn_wr_data,
  output logic [INC_WIDTH-1:0]         core_sn_byte_inc,
  output logic [N_CORES-1:0]           core_sn_wr_en,
  output logic [N_CORES-1:0]           core_sn_done,
  input  logic [N_CORES-1:0]           core_rdy_for_sn,
  output logic [N_CORES-1:0]           core_rdy_for_sn_ack,
  output logic [SEL_W-1:0]             sel,
  output logic [31:0]                  pkt_cnt,
  output logic                         stray_err
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             stray_q, stray_d;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;

  assign core_sn_addr     = sn_addr;
  assign core_sn_wr_data  = sn_wr_data;
  assign core_sn_byte_inc = sn_byte_inc;
  assign sel              = sel_q;
  assign pkt_cnt          = cnt_q;
  assign stray_err        = stray_q;

  rr_pick #(
    .N (N_CORES),
    .W (SEL_W)
  ) u_pick (
    .mask  (core_rdy_for_sn),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // State register; reset clears everything, even mid-packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end

  // Next state plus per-core strobes, steered by the held sel.
  always_comb begin
    state_d             = state_q;
    sel_d               = sel_q;
    ptr_d               = ptr_q;
    cnt_d               = cnt_q;
    stray_d             = stray_q;
    rdy_for_sn          = 1'b0;
    core_sn_wr_en       = '0;
    core_sn_done        = '0;
    core_rdy_for_sn_ack = '0;
    if (state_q != ST_BUSY && (sn_wr_en || sn_done))
      stray_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        rdy_for_sn = core_rdy_for_sn[sel_q];
        if (!core_rdy_for_sn[sel_q]) begin
          state_d = ST_IDLE;
        end else if (rdy_for_sn_ack) begin
          core_rdy_for_sn_ack[sel_q] = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        core_sn_wr_en[sel_q] = sn_wr_en;
        core_sn_done[sel_q]  = sn_done;
        if (sn_done) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + 32'd1;
          ptr_d   = (sel_q == SEL_W'(N_CORES - 1))
                  ? '0 : sel_q + SEL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
